// File: rtl/intra_pkg.sv
// intra_pkg: shared types, TU size encoding, mode classes and the HEVC intraPredAngle table.
package intra_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {TU4, TU8, TU16, TU32} tu_size_t;
  localparam logic [5:0] PLANAR = 6'd0;
  localparam logic [5:0] DC = 6'd1;
  localparam logic [5:0] HOR_LAST = 6'd17;
  localparam logic [5:0] ANG_LAST = 6'd34;
  // One bit wider than the table needs for -32..31 so that +32 (modes 2 and 34) is representable.
  localparam int ANG_W = 7;
  localparam logic signed [ANG_W-1:0] ANG_LUT [0:32] = '{
    7'sd32, 7'sd26, 7'sd21, 7'sd17, 7'sd13, 7'sd9, 7'sd5, 7'sd2, 7'sd0,
    -7'sd2, -7'sd5, -7'sd9, -7'sd13, -7'sd17, -7'sd21, -7'sd26, -7'sd32,
    -7'sd26, -7'sd21, -7'sd17, -7'sd13, -7'sd9, -7'sd5, -7'sd2, 7'sd0,
    7'sd2, 7'sd5, 7'sd9, 7'sd13, 7'sd17, 7'sd21, 7'sd26, 7'sd32
  };
  function automatic logic is_ang(input logic [5:0] m);
    return m != PLANAR && m != DC && m <= ANG_LAST;
  endfunction
  function automatic logic signed [ANG_W-1:0] ang_of(input logic [5:0] m);
    return is_ang(m) ? ANG_LUT[m - 6'd2] : '0;
  endfunction
endpackage

// File: rtl/intra_l1_angcalc.sv
// intra_l1_angcalc: combinational per-row move/weight and saturated reference-window base for one 4x4 block.
module intra_l1_angcalc
  import intra_pkg::*;
#(
  parameter int REFB_W = 8
) (
  input  logic [2:0]              main,
  input  logic [2:0]              side,
  input  logic signed [ANG_W-1:0] angle,
  output logic [11:0]             move,
  output logic [19:0]             weight,
  output logic signed [REFB_W-1:0] ref_base
);
  localparam logic signed [11:0] RB_MAX = 12'((1 << (REFB_W - 1)) - 1);
  localparam logic signed [11:0] RB_MIN = -RB_MAX - 12'sd1;
  logic signed [11:0] ang, base, rb;
  logic signed [11:0] pos [4];
  logic signed [11:0] idx [4];
  always_comb begin
    ang = 12'(angle);
    move = '0;
    weight = '0;
    for (int i = 0; i < 4; i++) begin
      pos[i] = $signed(12'({main, 2'(i)}) + 12'd1) * ang;
      idx[i] = pos[i] >>> 5;
    end
    base = angle[ANG_W-1] ? idx[3] : idx[0];
    for (int i = 0; i < 4; i++) begin
      move[11-3*i -: 3] = 3'(idx[i] - base);
      weight[19-5*i -: 5] = pos[i][4:0];
    end
    rb = base + $signed(12'({side, 2'b00}));
    ref_base = rb > RB_MAX ? RB_MAX[REFB_W-1:0] : rb < RB_MIN ? RB_MIN[REFB_W-1:0] : rb[REFB_W-1:0];
  end
endmodule

// File: rtl/intra_l1_sched.sv
// intra_l1_sched: walks one TU in 4x4 blocks and drives the L1 intra datapath controls.
// INTRA_L1_SCHED_COLSCAN_EN: horizontal-class jobs scan column-major instead of raster.
module intra_l1_sched
  import intra_pkg::*;
#(
  parameter int bitDepth = 8,
  parameter int REFB_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [1:0]               tu_size,
  input  logic [5:0]               pred_mode,
  output logic                     blk_valid,
  input  logic                     blk_ready,
  output logic                     bStop,
  output logic [2:0]               X,
  output logic [2:0]               Y,
  output logic [11:0]              move,
  output logic [19:0]              weight,
  output logic signed [REFB_W-1:0] ref_base,
  output logic                     transpose,
  output logic                     done
);
  state_t state_q, state_d;
  tu_size_t size_q, size_d;
  logic [5:0] mode_q, mode_d, m;
  logic blk_valid_q, blk_valid_d, done_q, done_d, transpose_q, transpose_d;
  logic [2:0] x_q, x_d, y_q, y_d, lim, nx, ny, c_main, c_side;
  logic [11:0] move_q, move_d, c_move;
  logic [19:0] weight_q, weight_d, c_weight;
  logic signed [REFB_W-1:0] ref_base_q, ref_base_d, c_ref;
  logic idle, accept, hs, col, wrap_x, wrap_y, last, load, ang, hor;
  always_comb begin
    idle = state_q == IDLE;
    accept = idle & start_valid;
    hs = blk_valid_q & blk_ready;
    lim = 3'((4'd1 << size_q) - 4'd1);
`ifdef INTRA_L1_SCHED_COLSCAN_EN
    col = transpose_q;
`else
    col = 1'b0;
`endif
    wrap_x = x_q == lim;
    wrap_y = y_q == lim;
    last = wrap_x & wrap_y;
    nx = idle ? 3'd0 : col ? (wrap_y ? x_q + 3'd1 : x_q) : (wrap_x ? 3'd0 : x_q + 3'd1);
    ny = idle ? 3'd0 : col ? (wrap_y ? 3'd0 : y_q + 3'd1) : (wrap_x ? y_q + 3'd1 : y_q);
    // During acceptance the job is not latched yet, so the first block uses the live mode.
    m = idle ? pred_mode : mode_q;
    ang = is_ang(m);
    hor = ang && m <= HOR_LAST;
    c_main = hor ? nx : ny;
    c_side = hor ? ny : nx;
    load = idle ? start_valid : hs & ~last;
    state_d = idle ? (start_valid ? RUN : IDLE) : (hs & last ? IDLE : RUN);
    size_d = accept ? tu_size_t'(tu_size) : size_q;
    mode_d = accept ? pred_mode : mode_q;
    transpose_d = accept ? hor : transpose_q;
    blk_valid_d = load | (blk_valid_q & ~hs);
    done_d = ~idle & hs & last;
    x_d = load ? nx : x_q;
    y_d = load ? ny : y_q;
    move_d = load ? (ang ? c_move : '0) : move_q;
    weight_d = load ? (ang ? c_weight : '0) : weight_q;
    ref_base_d = load ? (ang ? c_ref : '0) : ref_base_q;
  end
  intra_l1_angcalc #(.REFB_W(REFB_W)) u_angcalc (
    .main    (c_main),
    .side    (c_side),
    .angle   (ang_of(m)),
    .move    (c_move),
    .weight  (c_weight),
    .ref_base(c_ref)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      size_q <= TU4;
      mode_q <= '0;
      blk_valid_q <= 1'b0;
      done_q <= 1'b0;
      transpose_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      move_q <= '0;
      weight_q <= '0;
      ref_base_q <= '0;
    end else begin
      state_q <= state_d;
      size_q <= size_d;
      mode_q <= mode_d;
      blk_valid_q <= blk_valid_d;
      done_q <= done_d;
      transpose_q <= transpose_d;
      x_q <= x_d;
      y_q <= y_d;
      move_q <= move_d;
      weight_q <= weight_d;
      ref_base_q <= ref_base_d;
    end
  end
  assign start_ready = idle;
  assign blk_valid = blk_valid_q;
  assign bStop = blk_valid_q & ~blk_ready;
  assign X = x_q;
  assign Y = y_q;
  assign move = move_q;
  assign weight = weight_q;
  assign ref_base = ref_base_q;
  assign transpose = transpose_q;
  assign done = done_q;
endmodule

// File: tb/tb_intra_l1_sched.sv
// tb_intra_l1_sched: directed scenario tasks with hand-computed expectations for intra_l1_sched.
module tb_intra_l1_sched;
  logic clk = 1'b0, rst_n = 1'b0, start_valid = 1'b0, blk_ready = 1'b1;
  logic [1:0] tu_size = '0;
  logic [5:0] pred_mode = '0;
  logic start_ready, blk_valid, bStop, transpose, done;
  logic [2:0] X, Y;
  logic [11:0] move;
  logic [19:0] weight;
  logic signed [7:0] ref_base;
  int tests = 0, fails = 0;

  intra_l1_sched #(.bitDepth(8), .REFB_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .tu_size(tu_size), .pred_mode(pred_mode), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .bStop(bStop), .X(X), .Y(Y), .move(move), .weight(weight), .ref_base(ref_base),
    .transpose(transpose), .done(done)
  );

  always #5 clk = ~clk;

  task automatic start_job(input logic [1:0] s, input logic [5:0] md);
    int w = 0;
    while (!start_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    tests++;
    if (start_ready !== 1'b1) begin
      fails++;
      $display("FAIL start_wait: start_ready=%b required 1", start_ready);
    end
    tu_size = s;
    pred_mode = md;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({start_ready, blk_valid, bStop, done, transpose, X, Y, move, weight, ref_base} !== {5'b10000, 6'd0, 12'd0, 20'd0, 8'd0}) begin
      fails++;
      $display("FAIL reset: got %b%b%b%b%b X=%0d Y=%0d move=%h weight=%h ref=%0d required 10000 all zero",
               start_ready, blk_valid, bStop, done, transpose, X, Y, move, weight, ref_base);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mode26_raster;
    blk_ready = 1'b1;
    start_job(2'd1, 6'd26);
    for (int b = 0; b < 4; b++) begin
      tests++;
      if ({blk_valid, X, Y, move, weight, ref_base} !== {1'b1, 3'(b % 2), 3'(b / 2), 12'd0, 20'd0, 8'(4 * (b % 2))}) begin
        fails++;
        $display("FAIL m26_blk%0d: got v=%b X=%0d Y=%0d move=%h weight=%h ref=%0d required v=1 X=%0d Y=%0d move=0 weight=0 ref=%0d",
                 b, blk_valid, X, Y, move, weight, ref_base, b % 2, b / 2, 4 * (b % 2));
      end
      @(negedge clk);
    end
    tests++;
    if ({done, blk_valid, start_ready} !== 3'b101) begin
      fails++;
      $display("FAIL m26_done: got done=%b v=%b rdy=%b required 1 0 1", done, blk_valid, start_ready);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL m26_done_pulse: got done=%b required 0", done);
    end
  endtask

  task automatic test_angular_single;
    start_job(2'd0, 6'd29);
    tests++;
    if ({blk_valid, move, weight, ref_base, transpose} !== {1'b1, 12'h001, 5'd9, 5'd18, 5'd27, 5'd4, 8'd0, 1'b0}) begin
      fails++;
      $display("FAIL m29: got move=%h weight=%h ref=%0d tr=%b required move=001 weight=%h ref=0 tr=0",
               move, weight, ref_base, transpose, {5'd9, 5'd18, 5'd27, 5'd4});
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL m29_done: got %b required 1", done);
    end
    start_job(2'd0, 6'd18);
    tests++;
    if ({blk_valid, move, weight, ref_base, transpose} !== {1'b1, 12'h688, 20'd0, 8'hFC, 1'b0}) begin
      fails++;
      $display("FAIL m18: got move=%h weight=%h ref=%0d tr=%b required move=688 weight=0 ref=-4 tr=0",
               move, weight, ref_base, transpose);
    end
    @(negedge clk);
    start_job(2'd0, 6'd2);
    tests++;
    if ({blk_valid, move, weight, ref_base, transpose} !== {1'b1, 12'h053, 20'd0, 8'd1, 1'b1}) begin
      fails++;
      $display("FAIL m2: got move=%h weight=%h ref=%0d tr=%b required move=053 weight=0 ref=1 tr=1",
               move, weight, ref_base, transpose);
    end
    @(negedge clk);
  endtask

  task automatic test_horizontal_raster;
    start_job(2'd1, 6'd10);
    for (int b = 0; b < 4; b++) begin
      tests++;
      if ({blk_valid, X, Y, move, ref_base, transpose} !== {1'b1, 3'(b % 2), 3'(b / 2), 12'd0, 8'(4 * (b / 2)), 1'b1}) begin
        fails++;
        $display("FAIL m10_blk%0d: got X=%0d Y=%0d move=%h ref=%0d tr=%b required X=%0d Y=%0d move=0 ref=%0d tr=1",
                 b, X, Y, move, ref_base, transpose, b % 2, b / 2, 4 * (b / 2));
      end
      @(negedge clk);
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL m10_done: got %b required 1", done);
    end
  endtask

  task automatic test_nonangular;
    start_job(2'd1, 6'd0);
    for (int b = 0; b < 4; b++) begin
      tests++;
      if ({blk_valid, X, Y, move, weight, ref_base, transpose} !== {1'b1, 3'(b % 2), 3'(b / 2), 12'd0, 20'd0, 8'd0, 1'b0}) begin
        fails++;
        $display("FAIL planar_blk%0d: got X=%0d Y=%0d move=%h weight=%h ref=%0d tr=%b required X=%0d Y=%0d zeros",
                 b, X, Y, move, weight, ref_base, transpose, b % 2, b / 2);
      end
      @(negedge clk);
    end
    start_job(2'd0, 6'd40);
    tests++;
    if ({blk_valid, move, weight, ref_base, transpose} !== {1'b1, 12'd0, 20'd0, 8'd0, 1'b0}) begin
      fails++;
      $display("FAIL illegal_mode: got v=%b move=%h weight=%h ref=%0d tr=%b required v=1 zeros",
               blk_valid, move, weight, ref_base, transpose);
    end
    @(negedge clk);
    tests++;
    if ({done, blk_valid} !== 2'b10) begin
      fails++;
      $display("FAIL illegal_done: got done=%b v=%b required 1 0", done, blk_valid);
    end
  endtask

  task automatic test_stall;
    int hs = 0, stops = 0, cyc = 0, exp_ref;
    logic stall;
    start_job(2'd2, 6'd34);
    while (hs < 16 && cyc < 60) begin
      stall = (hs == 5 && stops < 3);
      blk_ready = ~stall;
      #1;
      exp_ref = 4 * (hs / 4) + 1 + 4 * (hs % 4);
      tests++;
      if ({blk_valid, bStop, X, Y, move, weight, ref_base} !== {1'b1, stall, 3'(hs % 4), 3'(hs / 4), 12'h053, 20'd0, 8'(exp_ref)}) begin
        fails++;
        $display("FAIL stall_blk%0d: got v=%b stop=%b X=%0d Y=%0d move=%h ref=%0d required v=1 stop=%b X=%0d Y=%0d move=053 ref=%0d",
                 hs, blk_valid, bStop, X, Y, move, ref_base, stall, hs % 4, hs / 4, exp_ref);
      end
      if (stall) stops++;
      else hs++;
      @(negedge clk);
      cyc++;
    end
    blk_ready = 1'b1;
    tests++;
    if (hs != 16 || {done, blk_valid} !== 2'b10) begin
      fails++;
      $display("FAIL stall_done: got handshakes=%0d done=%b v=%b required 16 1 0", hs, done, blk_valid);
    end
  endtask

  task automatic test_back_to_back;
    blk_ready = 1'b1;
    start_job(2'd0, 6'd26);
    @(negedge clk);
    start_valid = 1'b1;
    tu_size = 2'd0;
    pred_mode = 6'd29;
    tests++;
    if ({done, start_ready} !== 2'b11) begin
      fails++;
      $display("FAIL b2b_done_cycle: got done=%b rdy=%b required 1 1", done, start_ready);
    end
    @(negedge clk);
    start_valid = 1'b0;
    tests++;
    if ({blk_valid, done, start_ready, weight} !== {3'b100, 5'd9, 5'd18, 5'd27, 5'd4}) begin
      fails++;
      $display("FAIL b2b_second: got v=%b done=%b rdy=%b weight=%h required 1 0 0 weight=%h",
               blk_valid, done, start_ready, weight, {5'd9, 5'd18, 5'd27, 5'd4});
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL b2b_second_done: got %b required 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    blk_ready = 1'b1;
    start_job(2'd3, 6'd26);
    repeat (2) @(negedge clk);
    tests++;
    if ({blk_valid, X, ref_base} !== {1'b1, 3'd2, 8'd8}) begin
      fails++;
      $display("FAIL rstmid_pre: got v=%b X=%0d ref=%0d required 1 2 8", blk_valid, X, ref_base);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if ({start_ready, blk_valid, bStop, done, transpose, X, Y, move, weight, ref_base} !== {5'b10000, 6'd0, 12'd0, 20'd0, 8'd0}) begin
      fails++;
      $display("FAIL rstmid_state: got %b%b%b%b%b X=%0d Y=%0d move=%h weight=%h ref=%0d required 10000 all zero",
               start_ready, blk_valid, bStop, done, transpose, X, Y, move, weight, ref_base);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if ({done, blk_valid} !== 2'b00) begin
        fails++;
        $display("FAIL rstmid_nodone%0d: got done=%b v=%b required 0 0", c, done, blk_valid);
      end
    end
  endtask

  initial begin
    test_reset;
    test_mode26_raster;
    test_angular_single;
    test_horizontal_raster;
    test_nonangular;
    test_stall;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
